// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared fetch-pipeline configuration: FSM state encodings, default
// flush/timeout settings and datapath widths used by the pipeline stages.
package fetch_pipe_ctrl_pkg;

   localparam int unsigned STATE_W      = 2;
   localparam int unsigned PC_W         = 32;
   localparam int unsigned CNT_W        = 32;
   localparam int unsigned FLUSH_CNT_W  = 3;
   localparam int unsigned MISS_TMR_W   = 8;

   localparam int unsigned DEFAULT_FLUSH_CYCLES = 2;
   localparam int unsigned DEFAULT_MISS_TIMEOUT = 255;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN       = 2'd0,
      ST_MISS_WAIT = 2'd1,
      ST_FLUSH     = 2'd2,
      ST_REDIRECT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports: CLK, RESET (async active-low), enable (count this cycle),
//        clear (sync clear, wins over enable), value (current count).
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             enable,
   input  logic             clear,
   output logic [WIDTH-1:0] value
);

   // Hold at all-ones once reached
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (enable && (value != '1)) begin
         value <= value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch pipeline control: arbitrates mispredict flush/redirect, I-cache
// miss waits and back-end stalls into fetch-side STALL/FLUSH/REDIRECT.
// Ports:
//   CLK, RESET (async active-low)
//   ICACHE_MISS, ICACHE_READY        I-cache miss / refill done
//   MISPREDICT, MISPREDICT_PC[31:0]  branch correction and its target
//   LOAD_USE, MEM_STALL              same-cycle hazards
//   STALL_FE, FLUSH_FE               fetch-side freeze / bubble
//   REDIRECT_VALID, REDIRECT_PC      one-cycle PC load
//   MISS_TO_ERR                      sticky miss-timeout flag
//   STALL_CYCLES[31:0]               saturating stalled-cycle count
//   STATE_DBG[1:0]                   registered FSM state
module fetch_pipe_ctrl
   import fetch_pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
   parameter int unsigned MISS_TIMEOUT = DEFAULT_MISS_TIMEOUT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ICACHE_MISS,
   input  logic        ICACHE_READY,
   input  logic        MISPREDICT,
   input  logic [31:0] MISPREDICT_PC,
   input  logic        LOAD_USE,
   input  logic        MEM_STALL,
   output logic        STALL_FE,
   output logic        FLUSH_FE,
   output logic        REDIRECT_VALID,
   output logic [31:0] REDIRECT_PC,
   output logic        MISS_TO_ERR,
   output logic [31:0] STALL_CYCLES,
   output logic [1:0]  STATE_DBG
);

   fetch_state_t          state;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
   logic [MISS_TMR_W-1:0]  miss_timer;
   logic [PC_W-1:0]        redirect_pc;
   logic                   miss_to_err;

   // State register: mispredict overrides everything, from any state
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= ST_RUN;
         flush_cnt   <= '0;
         miss_timer  <= '0;
         redirect_pc <= '0;
         miss_to_err <= 1'b0;
      end else if (MISPREDICT) begin
         state       <= ST_FLUSH;
         flush_cnt   <= FLUSH_CNT_W'(1);
         miss_timer  <= '0;
         redirect_pc <= MISPREDICT_PC;
      end else begin
         case (state)
            ST_RUN: begin
               if (ICACHE_MISS) begin
                  state      <= ST_MISS_WAIT;
                  miss_timer <= '0;
               end
            end
            ST_MISS_WAIT: begin
               // Timer saturates; error latches when the count reaches the limit
               if (miss_timer != '1) begin
                  miss_timer <= miss_timer + MISS_TMR_W'(1);
               end
               if ((miss_timer + MISS_TMR_W'(1)) == MISS_TMR_W'(MISS_TIMEOUT)) begin
                  miss_to_err <= 1'b1;
               end
               if (ICACHE_READY) begin
                  state      <= ST_RUN;
                  miss_timer <= '0;
               end
            end
            ST_FLUSH: begin
               // flush_cnt holds the 1-based index of the current flush cycle
               if (flush_cnt >= FLUSH_CNT_W'(FLUSH_CYCLES)) begin
                  state     <= ST_REDIRECT;
                  flush_cnt <= '0;
               end else begin
                  flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
               end
            end
            ST_REDIRECT: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // Output decode from registered state plus same-cycle hazards; forced low in reset
   always_comb begin
      STALL_FE       = 1'b0;
      FLUSH_FE       = 1'b0;
      REDIRECT_VALID = 1'b0;
      if (RESET) begin
         case (state)
            ST_RUN:       STALL_FE = !MISPREDICT && (MEM_STALL || LOAD_USE || ICACHE_MISS);
            ST_MISS_WAIT: STALL_FE = 1'b1;
            ST_FLUSH:     FLUSH_FE = 1'b1;
            ST_REDIRECT:  REDIRECT_VALID = 1'b1;
            default:      STALL_FE = 1'b0;
         endcase
      end
   end

   assign REDIRECT_PC = redirect_pc;
   assign MISS_TO_ERR = miss_to_err;
   assign STATE_DBG   = state;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .CLK    (CLK),
      .RESET  (RESET),
      .enable (STALL_FE),
      .clear  (1'b0),
      .value  (STALL_CYCLES)
   );

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Bench for fetch_pipe_ctrl: directed scenarios on a default instance and
// a short-timeout instance, plus random traffic against a reference model.
module tb_fetch_pipe_ctrl;

   localparam int unsigned F4 = 3;
   localparam int unsigned T4 = 4;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        ICACHE_MISS, ICACHE_READY, MISPREDICT, LOAD_USE, MEM_STALL;
   logic [31:0] MISPREDICT_PC;

   logic        stall_a, flush_a, rv_a, err_a;
   logic [31:0] pc_a, cnt_a;
   logic [1:0]  st_a;
   logic        stall_b, flush_b, rv_b, err_b;
   logic [31:0] pc_b, cnt_b;
   logic [1:0]  st_b;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   fetch_pipe_ctrl dut (
      .CLK(CLK), .RESET(RESET), .ICACHE_MISS(ICACHE_MISS), .ICACHE_READY(ICACHE_READY),
      .MISPREDICT(MISPREDICT), .MISPREDICT_PC(MISPREDICT_PC), .LOAD_USE(LOAD_USE),
      .MEM_STALL(MEM_STALL), .STALL_FE(stall_a), .FLUSH_FE(flush_a),
      .REDIRECT_VALID(rv_a), .REDIRECT_PC(pc_a), .MISS_TO_ERR(err_a),
      .STALL_CYCLES(cnt_a), .STATE_DBG(st_a));

   fetch_pipe_ctrl #(.FLUSH_CYCLES(F4), .MISS_TIMEOUT(T4)) dut4 (
      .CLK(CLK), .RESET(RESET), .ICACHE_MISS(ICACHE_MISS), .ICACHE_READY(ICACHE_READY),
      .MISPREDICT(MISPREDICT), .MISPREDICT_PC(MISPREDICT_PC), .LOAD_USE(LOAD_USE),
      .MEM_STALL(MEM_STALL), .STALL_FE(stall_b), .FLUSH_FE(flush_b),
      .REDIRECT_VALID(rv_b), .REDIRECT_PC(pc_b), .MISS_TO_ERR(err_b),
      .STALL_CYCLES(cnt_b), .STATE_DBG(st_b));

   task automatic clear_inputs;
      ICACHE_MISS = 1'b0; ICACHE_READY = 1'b0; MISPREDICT = 1'b0;
      LOAD_USE = 1'b0; MEM_STALL = 1'b0; MISPREDICT_PC = 32'h0;
   endtask

   task automatic next_cycle;
      @(posedge CLK);
      #1;
   endtask

   // Leaves the bench 1 time unit after a rising edge, cycle 0 in RUN
   task automatic do_reset;
      clear_inputs();
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
   endtask

   task automatic test_reset;
      clear_inputs();
      RESET = 1'b0;
      MEM_STALL = 1'b1; LOAD_USE = 1'b1; ICACHE_MISS = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall_a); end
      total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", flush_a); end
      total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", rv_a); end
      total++; if (cnt_a !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", cnt_a); end
      total++; if (pc_a !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_a); end
      total++; if (err_a !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_a); end
      do_reset();
      repeat (5) next_cycle();
      @(negedge CLK);
      total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", stall_a); end
      total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL idle_flush got=%b want=0", flush_a); end
      total++; if (st_a !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", st_a); end
      total++; if (cnt_a !== 32'h0) begin bad++; $display("FAIL idle_cnt got=%0d want=0", cnt_a); end
   endtask

   task automatic test_miss_refill;
      logic       e_stall;
      logic [1:0] e_st;
      do_reset();
      for (int c = 0; c <= 17; c++) begin
         ICACHE_MISS  = (c == 10);
         ICACHE_READY = (c == 14);
         e_stall = (c >= 10 && c <= 14);
         e_st    = (c >= 11 && c <= 14) ? 2'd1 : 2'd0;
         @(negedge CLK);
         total++; if (stall_a !== e_stall) begin bad++; $display("FAIL miss_stall c=%0d got=%b want=%b", c, stall_a, e_stall); end
         total++; if (st_a !== e_st) begin bad++; $display("FAIL miss_state c=%0d got=%0d want=%0d", c, st_a, e_st); end
         next_cycle();
      end
      @(negedge CLK);
      total++; if (cnt_a !== 32'd5) begin bad++; $display("FAIL miss_cnt got=%0d want=5", cnt_a); end
   endtask

   task automatic test_mispredict;
      logic       e_flush, e_rv;
      logic [1:0] e_st;
      do_reset();
      for (int c = 0; c <= 26; c++) begin
         MISPREDICT    = (c == 20);
         MISPREDICT_PC = (c == 20) ? 32'h0000_0400 : $urandom();
         e_flush = (c == 21 || c == 22);
         e_rv    = (c == 23);
         e_st    = e_flush ? 2'd2 : (e_rv ? 2'd3 : 2'd0);
         @(negedge CLK);
         total++; if (flush_a !== e_flush) begin bad++; $display("FAIL mp_flush c=%0d got=%b want=%b", c, flush_a, e_flush); end
         total++; if (rv_a !== e_rv) begin bad++; $display("FAIL mp_rv c=%0d got=%b want=%b", c, rv_a, e_rv); end
         total++; if (st_a !== e_st) begin bad++; $display("FAIL mp_state c=%0d got=%0d want=%0d", c, st_a, e_st); end
         total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL mp_stall c=%0d got=%b want=0", c, stall_a); end
         if (c == 23) begin
            total++; if (pc_a !== 32'h400) begin bad++; $display("FAIL mp_pc got=%h want=00000400", pc_a); end
         end
         next_cycle();
      end
   endtask

   task automatic test_mispredict_in_miss;
      logic       e_stall, e_flush;
      logic [1:0] e_st;
      int         pulses;
      pulses = 0;
      do_reset();
      for (int c = 0; c <= 15; c++) begin
         ICACHE_MISS   = (c == 2);
         MISPREDICT    = (c == 5 || c == 7);
         MISPREDICT_PC = (c == 5) ? 32'h100 : ((c == 7) ? 32'h200 : $urandom());
         e_stall = (c >= 2 && c <= 5);
         e_flush = (c >= 6 && c <= 9);
         e_st    = (c >= 3 && c <= 5) ? 2'd1 : (e_flush ? 2'd2 : ((c == 10) ? 2'd3 : 2'd0));
         @(negedge CLK);
         total++; if (stall_a !== e_stall) begin bad++; $display("FAIL mpm_stall c=%0d got=%b want=%b", c, stall_a, e_stall); end
         total++; if (flush_a !== e_flush) begin bad++; $display("FAIL mpm_flush c=%0d got=%b want=%b", c, flush_a, e_flush); end
         total++; if (st_a !== e_st) begin bad++; $display("FAIL mpm_state c=%0d got=%0d want=%0d", c, st_a, e_st); end
         if (rv_a === 1'b1) begin
            pulses++;
            total++; if (pc_a !== 32'h200) begin bad++; $display("FAIL mpm_pc c=%0d got=%h want=00000200", c, pc_a); end
         end
         next_cycle();
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL mpm_pulses got=%0d want=1", pulses); end
   endtask

   task automatic test_timeout;
      logic       e_err;
      logic [1:0] e_st;
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         ICACHE_MISS  = (c == 1);
         ICACHE_READY = (c == 9);
         e_err = (c >= 6);
         e_st  = (c >= 2 && c <= 9) ? 2'd1 : 2'd0;
         @(negedge CLK);
         total++; if (err_b !== e_err) begin bad++; $display("FAIL to_err c=%0d got=%b want=%b", c, err_b, e_err); end
         total++; if (st_b !== e_st) begin bad++; $display("FAIL to_state c=%0d got=%0d want=%0d", c, st_b, e_st); end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_flush;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         MISPREDICT    = (c == 3);
         MISPREDICT_PC = 32'h0000_0ABC;
         if (c == 5) RESET = 1'b1;
         if (c == 4) begin
            #1;
            total++; if (st_a !== 2'd2) begin bad++; $display("FAIL rmf_inflush got=%0d want=2", st_a); end
            RESET = 1'b0;
            @(negedge CLK);
            total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL rmf_flush got=%b want=0", flush_a); end
            total++; if (st_a !== 2'd0) begin bad++; $display("FAIL rmf_state got=%0d want=0", st_a); end
            total++; if (pc_a !== 32'h0) begin bad++; $display("FAIL rmf_pc got=%h want=0", pc_a); end
         end else begin
            @(negedge CLK);
            if (c >= 5) begin
               total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL rmf_rv c=%0d got=%b want=0", c, rv_a); end
               total++; if (st_a !== 2'd0) begin bad++; $display("FAIL rmf_after c=%0d got=%0d want=0", c, st_a); end
            end
         end
         next_cycle();
      end
   endtask

   // Random traffic on the FLUSH_CYCLES=3 / MISS_TIMEOUT=4 instance
   task automatic test_random;
      int                 m_state, m_flush_left, m_miss, r;
      logic               m_err, e_stall, e_flush, e_rv;
      logic [31:0]        m_pc;
      longint unsigned    m_cnt;
      m_state = 0; m_flush_left = 0; m_miss = 0; m_err = 1'b0; m_pc = 32'h0; m_cnt = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         r = int'($urandom_range(0, 9));
         MEM_STALL     = (r < 2);
         ICACHE_MISS   = (r >= 2 && r < 5);
         LOAD_USE      = ($urandom_range(0, 7) == 0);
         ICACHE_READY  = ($urandom_range(0, 3) == 0);
         MISPREDICT    = ($urandom_range(0, 15) == 0);
         MISPREDICT_PC = $urandom();
         if (m_state == 0) e_stall = !MISPREDICT && (MEM_STALL || LOAD_USE || ICACHE_MISS);
         else              e_stall = (m_state == 1);
         e_flush = (m_state == 2);
         e_rv    = (m_state == 3);
         @(negedge CLK);
         total++; if (stall_b !== e_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%b want=%b", c, stall_b, e_stall); end
         total++; if (flush_b !== e_flush) begin bad++; $display("FAIL rnd_flush c=%0d got=%b want=%b", c, flush_b, e_flush); end
         total++; if (rv_b !== e_rv) begin bad++; $display("FAIL rnd_rv c=%0d got=%b want=%b", c, rv_b, e_rv); end
         total++; if (st_b !== 2'(m_state)) begin bad++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, st_b, m_state); end
         total++; if (err_b !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err_b, m_err); end
         total++; if (cnt_b !== 32'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, cnt_b, m_cnt); end
         if (e_rv) begin
            total++; if (pc_b !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d got=%h want=%h", c, pc_b, m_pc); end
         end
         if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (MISPREDICT) begin
            m_pc = MISPREDICT_PC; m_state = 2; m_flush_left = F4; m_miss = 0;
         end else begin
            case (m_state)
               0: if (ICACHE_MISS) begin m_state = 1; m_miss = 0; end
               1: begin
                  m_miss++;
                  if (m_miss >= T4) m_err = 1'b1;
                  if (ICACHE_READY) begin m_state = 0; m_miss = 0; end
               end
               2: begin
                  m_flush_left--;
                  if (m_flush_left == 0) m_state = 3;
               end
               default: m_state = 0;
            endcase
         end
         next_cycle();
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_miss_refill();
      test_mispredict();
      test_mispredict_in_miss();
      test_timeout();
      test_reset_mid_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
